// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance-counter block: CSR map, event indices,
// mcountinhibit bit positions and default counter width.
package perf_pkg;

    localparam int CNT_W_DEF = 64;
    localparam int MAX_HPM   = 3;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // Counter slot order inside the unit; also the event-vector bit order.
    typedef enum logic [2:0] {
        EV_CYCLE   = 3'd0,
        EV_INSTRET = 3'd1,
        EV_STALL   = 3'd2,
        EV_FLUSH   = 3'd3,
        EV_LWSTALL = 3'd4
    } event_e;

    localparam int INH_CY   = 0;
    localparam int INH_IR   = 2;
    localparam int INH_HPM0 = 3;

    // mcountinhibit bit that gates counter slot idx (slot 1 skips the reserved bit 1).
    function automatic int inh_bit(input int idx);
        return (idx == 0) ? INH_CY : ((idx == 1) ? INH_IR : INH_HPM0 + idx - 2);
    endfunction

    // Writable mcountinhibit bits for a given number of event counters.
    function automatic logic [31:0] inh_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0;
        m[INH_CY] = 1'b1;
        m[INH_IR] = 1'b1;
        for (int j = 0; j < MAX_HPM; j++) begin
            if (j < num_hpm) m[INH_HPM0 + j] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/perf_counter_unit_if.sv
// CSR access port of the performance-counter block: request strobe, address and
// write data toward the unit; registered read data, valid and error back.
interface perf_counter_unit_if;

    logic        csr_en;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_err;

    modport master (
        output csr_en, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, csr_rvalid, csr_err
    );

    modport slave (
        input  csr_en, csr_we, csr_addr, csr_wdata,
        output csr_rdata, csr_rvalid, csr_err
    );

endinterface

// File: rtl/perf_counter_unit_counter.sv
// One CNT_W-bit event counter with split 32-bit low/high write ports.
// A write in the same cycle as an increment takes priority and the increment is lost.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             inhibit_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] value_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-counter unit: mcycle/minstret/mhpmcounter3..5 plus mcountinhibit
// behind a 1-cycle CSR port. Define PERF_HI_LATCH_EN for coherent lo/hi reads.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_HPM = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                retire_valid_i,
    input  logic                stall_f_i,
    input  logic                flush_e_i,
    input  logic                lw_stall_i,
    perf_counter_unit_if.slave  csr
);

    localparam int          NUM_CNT   = 2 + NUM_HPM;
    localparam logic [2:0]  NUM_CNT_L = 3'(NUM_CNT);
    localparam int          HI_W      = CNT_W - 32;
    localparam logic [31:0] INH_MASK  = inh_mask(NUM_HPM);

    logic [CNT_W-1:0]   cnt_val [NUM_CNT];
    logic [4:0]         ev_all;
    logic [NUM_CNT-1:0] ev;
    logic [NUM_CNT-1:0] wr_lo;
    logic [NUM_CNT-1:0] wr_hi;
    logic [NUM_CNT-1:0] inh;

    logic [31:0] inh_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        rvalid_q;
    logic        err_q;
    logic        err_d;

    logic        inh_hit;
    logic        cnt_hit;
    logic        ro_hit;
    logic        hi_sel;
    logic [2:0]  sel;
    logic        legal;
    logic        wr_cnt;
    logic        rd_lo;
    logic [CNT_W-1:0] sel_val;
    logic [HI_W-1:0]  hi_src;

    always_comb begin
        ev_all             = '0;
        ev_all[EV_CYCLE]   = 1'b1;
        ev_all[EV_INSTRET] = retire_valid_i;
        ev_all[EV_STALL]   = stall_f_i;
        ev_all[EV_FLUSH]   = flush_e_i;
        ev_all[EV_LWSTALL] = lw_stall_i;
    end

    assign ev = ev_all[NUM_CNT-1:0];

    // Address decode: bit 7 selects the high half, bits [2:0] pick the counter.
    always_comb begin
        inh_hit = 1'b0;
        cnt_hit = 1'b0;
        ro_hit  = 1'b0;
        hi_sel  = csr.csr_addr[7];
        sel     = (csr.csr_addr[2:0] == 3'd0) ? 3'd0 : csr.csr_addr[2:0] - 3'd1;
        if (csr.csr_addr == CSR_MCOUNTINHIBIT) begin
            inh_hit = 1'b1;
        end else if (csr.csr_addr[11:8] == 4'hB && csr.csr_addr[6:3] == 4'h0 &&
                     csr.csr_addr[2:0] inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5}) begin
            cnt_hit = 1'b1;
        end else if (csr.csr_addr[11:8] == 4'hC && csr.csr_addr[6:2] == 5'h0 &&
                     csr.csr_addr[1:0] inside {2'd0, 2'd2}) begin
            cnt_hit = 1'b1;
            ro_hit  = 1'b1;
        end
    end

    assign legal  = inh_hit || (cnt_hit && (sel < NUM_CNT_L) && !(ro_hit && csr.csr_we));
    assign err_d  = csr.csr_en && !legal;
    assign wr_cnt = csr.csr_en && csr.csr_we && cnt_hit && legal;
    assign rd_lo  = csr.csr_en && !csr.csr_we && cnt_hit && legal && !hi_sel;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign wr_lo[i] = wr_cnt && !hi_sel && (sel == 3'(i));
        assign wr_hi[i] = wr_cnt &&  hi_sel && (sel == 3'(i));
        assign inh[i]   = inh_q[inh_bit(i)];

        perf_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_i     (ev[i]),
            .inhibit_i (inh[i]),
            .wr_lo_i   (wr_lo[i]),
            .wr_hi_i   (wr_hi[i]),
            .wdata_i   (csr.csr_wdata),
            .value_o   (cnt_val[i])
        );
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel == 3'(i)) sel_val = cnt_val[i];
        end
    end

`ifdef PERF_HI_LATCH_EN
    logic [HI_W-1:0] hi_lat_q [NUM_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) hi_lat_q[i] <= '0;
        end else if (rd_lo) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (sel == 3'(i)) hi_lat_q[i] <= sel_val[CNT_W-1:32];
            end
        end
    end

    always_comb begin
        hi_src = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel == 3'(i)) hi_src = hi_lat_q[i];
        end
    end
`else
    logic unused_rd_lo;
    assign unused_rd_lo = rd_lo;
    assign hi_src       = sel_val[CNT_W-1:32];
`endif

    // Old-value semantics: rdata always reflects state before this cycle's update.
    always_comb begin
        rdata_d = '0;
        if (legal) begin
            if (inh_hit) begin
                rdata_d = inh_q;
            end else if (hi_sel) begin
                rdata_d = 32'(hi_src);
            end else begin
                rdata_d = sel_val[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inh_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= csr.csr_en;
            err_q    <= err_d;
            if (csr.csr_en) begin
                rdata_q <= rdata_d;
            end
            if (csr.csr_en && csr.csr_we && inh_hit) begin
                inh_q <= csr.csr_wdata & INH_MASK;
            end
        end
    end

    assign csr.csr_rdata  = rdata_q;
    assign csr.csr_rvalid = rvalid_q;
    assign csr.csr_err    = err_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: per-cycle comparison against an
// arithmetic counter model plus hand-computed literal checkpoints.
module tb_perf_counter_unit;
    import perf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rv = 1'b0, sf = 1'b0, fe = 1'b0, lw = 1'b0;

    perf_counter_unit_if csr_if();

    perf_counter_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .retire_valid_i (rv),
        .stall_f_i      (sf),
        .flush_e_i      (fe),
        .lw_stall_i     (lw),
        .csr            (csr_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_cnt [5];
    logic [31:0] m_lat [5];
    logic [31:0] m_inh;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_cnt[k] = 64'd0;
            m_lat[k] = 32'd0;
        end
        m_inh     = 32'd0;
        exp_valid = 1'b0;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
    endtask

    function automatic void decode(input logic [11:0] a, output int idx, output bit hi,
                                   output bit ro, output bit is_inh);
        idx = -1; hi = 0; ro = 0; is_inh = 0;
        case (a)
            12'h320: is_inh = 1;
            12'hB00: idx = 0;
            12'hB80: begin idx = 0; hi = 1; end
            12'hB02: idx = 1;
            12'hB82: begin idx = 1; hi = 1; end
            12'hB03: idx = 2;
            12'hB83: begin idx = 2; hi = 1; end
            12'hB04: idx = 3;
            12'hB84: begin idx = 3; hi = 1; end
            12'hB05: idx = 4;
            12'hB85: begin idx = 4; hi = 1; end
            12'hC00: begin idx = 0; ro = 1; end
            12'hC80: begin idx = 0; hi = 1; ro = 1; end
            12'hC02: begin idx = 1; ro = 1; end
            12'hC82: begin idx = 1; hi = 1; ro = 1; end
            default: idx = -1;
        endcase
    endfunction

    // One clock of architectural effect for the inputs currently driven.
    task automatic model_step();
        int          idx;
        bit          hi, ro, is_inh, ok;
        bit          ev [5];
        int          inh_pos [5];
        logic [63:0] old [5];
        ev      = '{1'b1, rv, sf, fe, lw};
        inh_pos = '{0, 2, 3, 4, 5};
        for (int k = 0; k < 5; k++) old[k] = m_cnt[k];
        decode(csr_if.csr_addr, idx, hi, ro, is_inh);
        ok = is_inh || (idx >= 0 && !(ro && csr_if.csr_we));
        exp_valid = csr_if.csr_en;
        if (csr_if.csr_en) begin
            exp_err = !ok;
            if (!ok) exp_rdata = 32'd0;
            else if (is_inh) exp_rdata = m_inh;
            else if (!hi) exp_rdata = old[idx][31:0];
`ifdef PERF_HI_LATCH_EN
            else exp_rdata = m_lat[idx];
            if (ok && !csr_if.csr_we && !is_inh && !hi) m_lat[idx] = old[idx][63:32];
`else
            else exp_rdata = old[idx][63:32];
`endif
        end
        for (int k = 0; k < 5; k++) begin
            if (ev[k] && !m_inh[inh_pos[k]]) m_cnt[k] = old[k] + 64'd1;
        end
        if (csr_if.csr_en && csr_if.csr_we && ok) begin
            if (is_inh) m_inh = csr_if.csr_wdata & 32'h0000_003D;
            else if (hi) m_cnt[idx] = {csr_if.csr_wdata, old[idx][31:0]};
            else m_cnt[idx] = {old[idx][63:32], csr_if.csr_wdata};
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("rvalid_in_reset", csr_if.csr_rvalid, 1'b0);
        end else begin
            check("rvalid", csr_if.csr_rvalid, exp_valid);
            if (exp_valid) begin
                check("rdata", csr_if.csr_rdata, exp_rdata);
                check("err", csr_if.csr_err, exp_err);
            end
        end
    end

    task automatic cycle(input bit en, input bit we, input logic [11:0] a, input logic [31:0] wd,
                         input bit r, input bit s, input bit f, input bit l);
        csr_if.csr_en    = en;
        csr_if.csr_we    = we;
        csr_if.csr_addr  = a;
        csr_if.csr_wdata = wd;
        rv = r; sf = s; fe = f; lw = l;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 12'h000, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(1, 0, a, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cycle(1, 1, a, d, 0, 0, 0, 0);
    endtask

    logic [9:0] rv_pat, sf_pat, fe_pat, lw_pat;

    initial begin
        csr_if.csr_en    = 1'b0;
        csr_if.csr_we    = 1'b0;
        csr_if.csr_addr  = 12'h0;
        csr_if.csr_wdata = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rvalid", csr_if.csr_rvalid, 1'b0);
        check("reset_rdata", csr_if.csr_rdata, 32'h0);
        check("reset_err", csr_if.csr_err, 1'b0);
        rst_n = 1'b1;

        idle(100);
        rd(CSR_MCYCLE);
        check("mcycle_after_100", csr_if.csr_rdata, 32'd100);
        rd(CSR_MINSTRET);
        check("minstret_idle", csr_if.csr_rdata, 32'd0);
        check("minstret_idle_err", csr_if.csr_err, 1'b0);

        rv_pat = 10'b1101101101;
        sf_pat = 10'b0000110000;
        fe_pat = 10'b0100000000;
        lw_pat = 10'b0000000011;
        for (int i = 0; i < 10; i++) cycle(0, 0, 12'h0, 32'h0, rv_pat[i], sf_pat[i], fe_pat[i], lw_pat[i]);
        rd(CSR_MINSTRET);
        check("minstret_7", csr_if.csr_rdata, 32'd7);
        rd(12'hB03);
        check("hpm3_2", csr_if.csr_rdata, 32'd2);
        rd(12'hB04);
        check("hpm4_1", csr_if.csr_rdata, 32'd1);
        rd(12'hB05);
        check("hpm5_2", csr_if.csr_rdata, 32'd2);

        wr(CSR_MCYCLE, 32'hFFFF_FFFF);
        wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
        idle(2);
        rd(CSR_MCYCLE);
        check("mcycle_wrap_lo", csr_if.csr_rdata, 32'd1);
        rd(CSR_MCYCLEH);
        check("mcycle_wrap_hi", csr_if.csr_rdata, 32'd0);
        wr(CSR_MCYCLE, 32'h0000_1234);
        rd(CSR_MCYCLE);
        check("mcycle_write_wins", csr_if.csr_rdata, 32'h0000_1234);
        cycle(1, 1, CSR_MINSTRET, 32'd50, 1, 0, 0, 0);
        check("minstret_old_value", csr_if.csr_rdata, 32'd7);
        rd(CSR_MINSTRET);
        check("minstret_write_wins", csr_if.csr_rdata, 32'd50);

        wr(CSR_MCOUNTINHIBIT, 32'h0000_0007);
        wr(CSR_MCYCLE, 32'h0000_0500);
        wr(CSR_MINSTRET, 32'h0000_0600);
        repeat (5) cycle(0, 0, 12'h0, 32'h0, 1, 1, 0, 0);
        rd(CSR_MCYCLE);
        check("mcycle_frozen", csr_if.csr_rdata, 32'h0000_0500);
        rd(CSR_MINSTRET);
        check("minstret_frozen", csr_if.csr_rdata, 32'h0000_0600);
        rd(CSR_MCOUNTINHIBIT);
        check("inhibit_readback", csr_if.csr_rdata, 32'h0000_0005);
        rd(12'hB03);
        check("hpm3_not_inhibited", csr_if.csr_rdata, 32'd7);
        wr(CSR_MCOUNTINHIBIT, 32'h0000_0000);
        rd(CSR_INSTRET);
        wr(CSR_MCOUNTINHIBIT, 32'h0000_0001);
        idle(3);
        rd(CSR_CYCLE);
        wr(CSR_MCOUNTINHIBIT, 32'h0000_0000);

        wr(CSR_CYCLE, 32'h0000_0077);
        check("ro_write_err", csr_if.csr_err, 1'b1);
        check("ro_write_rdata", csr_if.csr_rdata, 32'h0);
        rd(CSR_MCYCLEH);
        rd(12'h7C0);
        check("unmapped_err", csr_if.csr_err, 1'b1);
        check("unmapped_rdata", csr_if.csr_rdata, 32'h0);
        rd(12'hB06);
        rd(CSR_INSTRETH);
        rd(CSR_CYCLEH);

        wr(CSR_MCYCLEH, 32'h0);
        wr(CSR_MCYCLE, 32'hFFFF_FFFE);
        rd(CSR_MCYCLE);
        check("latch_setup_lo", csr_if.csr_rdata, 32'hFFFF_FFFE);
        idle(5);
        rd(CSR_MCYCLEH);
`ifdef PERF_HI_LATCH_EN
        check("hi_latched", csr_if.csr_rdata, 32'd0);
`else
        check("hi_live", csr_if.csr_rdata, 32'd1);
`endif

        csr_if.csr_en   = 1'b1;
        csr_if.csr_we   = 1'b0;
        csr_if.csr_addr = CSR_MINSTRET;
        model_step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        csr_if.csr_en = 1'b0;
        #1;
        check("rst_mid_rvalid", csr_if.csr_rvalid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(CSR_MINSTRET);
        check("rst_minstret", csr_if.csr_rdata, 32'd0);
        rd(12'hB03);
        check("rst_hpm3", csr_if.csr_rdata, 32'd0);
        rd(CSR_MCOUNTINHIBIT);
        check("rst_inhibit", csr_if.csr_rdata, 32'd0);
        rd(CSR_MCYCLE);
        check("rst_mcycle", csr_if.csr_rdata, 32'd3);
        rd(CSR_MCYCLEH);
        for (int i = 0; i < 6; i++) cycle(1, 0, CSR_MCYCLE + 12'(i), 32'h0, i[0], i[1], 1, 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
